// File: rtl/mdu_multicycle_if.sv
`default_nettype none
// ============================================================================
// Module      : mdu_multicycle_if
// Description : Request/response bundle between the EX stage and the
//               multi-cycle multiply/divide unit.
//   master : drives MDU_i_Operand1/2, MDU_i_Operation, MDU_i_Start;
//            observes MDU_o_Busy, MDU_o_HI, MDU_o_LO
//   slave  : the MDU itself (directions reversed)
// Revision    : 1.0 - initial release
// ============================================================================
interface mdu_multicycle_if;
  logic [31:0] MDU_i_Operand1;
  logic [31:0] MDU_i_Operand2;
  logic [2:0]  MDU_i_Operation;
  logic        MDU_i_Start;
  logic        MDU_o_Busy;
  logic [31:0] MDU_o_HI;
  logic [31:0] MDU_o_LO;

  modport master (
    output MDU_i_Operand1, MDU_i_Operand2, MDU_i_Operation, MDU_i_Start,
    input  MDU_o_Busy, MDU_o_HI, MDU_o_LO
  );

  modport slave (
    input  MDU_i_Operand1, MDU_i_Operand2, MDU_i_Operation, MDU_i_Start,
    output MDU_o_Busy, MDU_o_HI, MDU_o_LO
  );
endinterface
`default_nettype wire

// File: rtl/mdu_multicycle.sv
`default_nettype none
// ============================================================================
// Module      : mdu_multicycle
// Description : Multi-cycle multiply/divide unit holding the HI/LO registers.
//               mult/multu/div/divu run for MULT_CYCLES/DIV_CYCLES with Busy
//               high and commit to HI/LO on the last busy edge; mthi/mtlo
//               write HI/LO in a single edge without raising Busy.
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset (aborts any in-flight op)
//   bus   : mdu_multicycle_if.slave (operands, operation, start, busy, HI, LO)
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_multicycle #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  wire             clk,
  input  wire             reset,
  mdu_multicycle_if.slave bus
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [2:0]         op_q,    op_d;
  logic [31:0]        a_q,     a_d;
  logic [31:0]        b_q,     b_d;
  logic [31:0]        hi_q,    hi_d;
  logic [31:0]        lo_q,    lo_d;

  // Result datapath, fed only from the operands latched at start.
  logic [63:0] prod_s, prod_u;
  logic [31:0] mag_a, mag_b, quo_mag, rem_mag;
  logic [31:0] quo_s, rem_s, quo_u, rem_u;

  always_comb begin
    prod_s  = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    prod_u  = {32'd0, a_q} * {32'd0, b_q};
    // Signed divide via magnitudes so 0x80000000 / -1 wraps to 0x80000000
    // instead of hitting a signed-overflow corner of the '/' operator.
    mag_a   = a_q[31] ? (~a_q + 32'd1) : a_q;
    mag_b   = b_q[31] ? (~b_q + 32'd1) : b_q;
    quo_mag = (mag_b == 32'd0) ? 32'd0 : mag_a / mag_b;
    rem_mag = (mag_b == 32'd0) ? 32'd0 : mag_a % mag_b;
    quo_s   = (a_q[31] ^ b_q[31]) ? (~quo_mag + 32'd1) : quo_mag;
    rem_s   = a_q[31] ? (~rem_mag + 32'd1) : rem_mag;
    quo_u   = (b_q == 32'd0) ? 32'd0 : a_q / b_q;
    rem_u   = (b_q == 32'd0) ? 32'd0 : a_q % b_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      S_IDLE: begin
        if (bus.MDU_i_Start) begin
          case (bus.MDU_i_Operation)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              op_d    = bus.MDU_i_Operation;
              a_d     = bus.MDU_i_Operand1;
              b_d     = bus.MDU_i_Operand2;
              cnt_d   = (bus.MDU_i_Operation == OP_MULT || bus.MDU_i_Operation == OP_MULTU)
                        ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
              state_d = S_BUSY;
            end
            OP_MTHI: hi_d = bus.MDU_i_Operand1;
            OP_MTLO: lo_d = bus.MDU_i_Operand1;
            default: ;
          endcase
        end
      end

      S_BUSY: begin
        // Start is deliberately not looked at here.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
          case (op_q)
            OP_MULT:  {hi_d, lo_d} = prod_s;
            OP_MULTU: {hi_d, lo_d} = prod_u;
            OP_DIV: begin
              if (b_q != 32'd0) begin
                lo_d = quo_s;
                hi_d = rem_s;
              end
            end
            OP_DIVU: begin
              if (b_q != 32'd0) begin
                lo_d = quo_u;
                hi_d = rem_u;
              end
            end
            default: ;
          endcase
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.MDU_o_Busy = (state_q == S_BUSY);
  assign bus.MDU_o_HI   = hi_q;
  assign bus.MDU_o_LO   = lo_q;

endmodule
`default_nettype wire

// File: doc/mdu_multicycle.md
Name: mdu_multicycle

Overview:
- Multi-cycle multiply/divide unit that sits beside the ALU in the EX stage of the pipelined MIPS core.
- Executes mult/multu/div/divu into the architectural HI/LO registers, handles mthi/mtlo writes, and presents HI/LO for mfhi/mflo.
- Raises a busy flag that the hazard unit uses to stall later MDU-dependent instructions.
- This is the sequential counterpart to the single-cycle ALU path.

Parameters:
- MULT_CYCLES, 5, cycles from accepted start to HI/LO commit for mult/multu.
- DIV_CYCLES, 10, cycles from accepted start to HI/LO commit for div/divu.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- MDU_i_Operand1  input  32  rs value; multiplicand or dividend; source for mthi/mtlo.
- MDU_i_Operand2  input  32  rt value; multiplier or divisor.
- MDU_i_Operation  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE).
- MDU_i_Start  input  1  one-cycle request qualifying MDU_i_Operation.
- MDU_o_Busy  output  1  high while an operation is in flight.
- MDU_o_HI  output  32  current HI register value.
- MDU_o_LO  output  32  current LO register value.

Behaviour:
- Reset: HI=0, LO=0, Busy=0, counter=0, state=IDLE. Reset during BUSY aborts the operation, and no commit occurs.
- States: IDLE and BUSY.
- IDLE:
  - Start=1 with MULT/MULTU/DIV/DIVU: latch both operands and the op, load counter with MULT_CYCLES or DIV_CYCLES, go to BUSY. Busy=1 from the next cycle.
  - Start=1 with MTHI: HI <= Operand1 at that edge. Busy stays 0.
  - Start=1 with MTLO: LO <= Operand1 at that edge. Busy stays 0.
  - Start=0, or op NONE/reserved: no change.
- BUSY:
  - Counter decrements each edge.
  - On the edge where the counter reaches 0, HI/LO take the result, state returns to IDLE, and Busy falls. Busy is therefore high for exactly N cycles, with N = MULT_CYCLES or DIV_CYCLES.
  - Start is ignored while Busy=1, including MTHI/MTLO; the hazard unit guarantees no request is issued then.
- HI/LO hold their old values throughout BUSY. Outputs are registered and change only at the commit edge or an mthi/mtlo edge.
- Results use the operands latched at start; operand inputs may change during BUSY without effect.
- MULT: signed 32x32 to 64-bit product; {HI,LO} = product.
- MULTU: unsigned 32x32 to 64-bit product; {HI,LO} = product.
- DIV: signed division.
  - LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0; no trap.
- DIVU: unsigned division; LO = quotient, HI = remainder.
- Divisor 0 (DIV/DIVU): still runs the full DIV_CYCLES with Busy high; HI and LO remain unchanged at commit.
- Start at the commit cycle: the request arrives while Busy=1 and is ignored. A new op may be accepted in the first cycle Busy=0.
- The unit raises no overflow or exception output.

Test Plan:
- Reset, then mult with Op1=0xFFFFFFFF (-1), Op2=0x00000002 -> Busy high for 5 cycles; HI=0xFFFFFFFF and LO=0xFFFFFFFE appear on the edge Busy falls; both are 0 before that.
- multu with Op1=0xFFFFFFFF, Op2=0x00000002 -> HI=0x00000001, LO=0xFFFFFFFE after 5 cycles.
- div with Op1=0xFFFFFFF9 (-7), Op2=0x00000002 -> Busy high 10 cycles, then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). divu with Op1=7, Op2=2 -> LO=3, HI=1.
- mthi 0x12345678 then mtlo 0x9ABCDEF0 in consecutive cycles with Busy=0 -> HI/LO update on the respective edges and Busy never asserts. Then div by 0 -> Busy high 10 cycles, HI/LO unchanged.
- Start mult, then assert reset on cycle 3 of BUSY -> Busy=0, HI=LO=0 on the next edge, and no later commit.
- Start divu, then pulse Start with MTLO 0xDEADBEEF during BUSY -> the MTLO is ignored; LO ends as the quotient.
